// File: rtl/cflash_read_seq.sv
// Sequences the SPI byte engine through a flash READ (0x03) and packs the returned bytes into 64-bit to-PC words.
// Latency: first spi_write 1 cycle after start; next byte issued 1 cycle after spi_busy is seen low.
// Backpressure: a full word is held in PUSH until tpc_ready; no SPI byte is issued meanwhile.
module cflash_read_seq #(
    parameter int LEN_BITS = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic [23:0]         addr,
    input  logic [LEN_BITS-1:0] nwords,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic                spi_write,
    output logic [8:0]          spi_wdata,
    input  logic                spi_busy,
    input  logic [7:0]          spi_rdata,
    input  logic                tpc_ready,
    output logic                tpc_write,
    output logic [63:0]         tpc_data
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD,
        S_A2,
        S_A1,
        S_A0,
        S_WT,
        S_PUSH,
        S_RWT,
        S_FIN
    } state_t;

    localparam logic [8:0] BYTE_RELEASE = 9'h100;
    localparam logic [8:0] BYTE_DUMMY   = 9'h000;
    localparam logic [LEN_BITS-1:0] ONE_WORD = {{(LEN_BITS-1){1'b0}}, 1'b1};

    state_t              state;
    logic [23:0]         addr_q;
    logic [LEN_BITS-1:0] words_left;
    logic [2:0]          byte_cnt;
    logic                abort_pend;

    // The byte engine only raises spi_busy the cycle after spi_write, so the
    // issue cycle itself must not be mistaken for a completed byte.
    logic byte_done;
    logic abort_now;
    assign byte_done = !spi_write && !spi_busy;
    assign abort_now = abort_pend || abort;

    // Combinational so the strobe can never outlive a tpc_ready drop.
    assign tpc_write = (state == S_PUSH) && tpc_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            spi_write  <= 1'b0;
            spi_wdata  <= BYTE_RELEASE;
            tpc_data   <= 64'h0;
            addr_q     <= 24'h0;
            words_left <= '0;
            byte_cnt   <= 3'd0;
            abort_pend <= 1'b0;
        end else begin
            done      <= 1'b0;
            spi_write <= 1'b0;
            if (abort && state != S_IDLE) begin
                abort_pend <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr_q     <= addr;
                        words_left <= nwords;
                        busy       <= 1'b1;
                        aborted    <= 1'b0;
                        abort_pend <= 1'b0;
                        byte_cnt   <= 3'd0;
                        if (nwords == '0) begin
                            state <= S_FIN;
                        end else begin
                            spi_write <= 1'b1;
                            spi_wdata <= 9'h003;
                            state     <= S_CMD;
                        end
                    end
                end

                S_CMD: begin
                    if (byte_done) begin
                        spi_write <= 1'b1;
                        if (abort_now) begin
                            spi_wdata <= BYTE_RELEASE;
                            state     <= S_RWT;
                        end else begin
                            spi_wdata <= {1'b0, addr_q[23:16]};
                            state     <= S_A2;
                        end
                    end
                end

                S_A2: begin
                    if (byte_done) begin
                        spi_write <= 1'b1;
                        if (abort_now) begin
                            spi_wdata <= BYTE_RELEASE;
                            state     <= S_RWT;
                        end else begin
                            spi_wdata <= {1'b0, addr_q[15:8]};
                            state     <= S_A1;
                        end
                    end
                end

                S_A1: begin
                    if (byte_done) begin
                        spi_write <= 1'b1;
                        if (abort_now) begin
                            spi_wdata <= BYTE_RELEASE;
                            state     <= S_RWT;
                        end else begin
                            spi_wdata <= {1'b0, addr_q[7:0]};
                            state     <= S_A0;
                        end
                    end
                end

                S_A0: begin
                    if (byte_done) begin
                        spi_write <= 1'b1;
                        if (abort_now) begin
                            spi_wdata <= BYTE_RELEASE;
                            state     <= S_RWT;
                        end else begin
                            spi_wdata <= BYTE_DUMMY;
                            state     <= S_WT;
                        end
                    end
                end

                // Read byte in flight; on completion pack it, then push, abort or fetch the next.
                S_WT: begin
                    if (byte_done) begin
                        tpc_data[{byte_cnt, 3'b000} +: 8] <= spi_rdata;
                        byte_cnt <= byte_cnt + 3'd1;
                        if (byte_cnt == 3'd7) begin
                            state <= S_PUSH;
                        end else if (abort_now) begin
                            spi_write <= 1'b1;
                            spi_wdata <= BYTE_RELEASE;
                            state     <= S_RWT;
                        end else begin
                            spi_write <= 1'b1;
                            spi_wdata <= BYTE_DUMMY;
                        end
                    end
                end

                S_PUSH: begin
                    if (tpc_ready) begin
                        words_left <= words_left - ONE_WORD;
                        spi_write  <= 1'b1;
                        if (words_left == ONE_WORD || abort_now) begin
                            spi_wdata <= BYTE_RELEASE;
                            state     <= S_RWT;
                        end else begin
                            spi_wdata <= BYTE_DUMMY;
                            state     <= S_WT;
                        end
                    end
                end

                S_RWT: begin
                    if (byte_done) begin
                        state <= S_FIN;
                    end
                end

                S_FIN: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    aborted <= abort_pend;
                    state   <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
